// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a circular output FIFO and active-low RTS flow control.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) and the io_parityError pulse.
module uart_rx_fifo #(
`ifdef UART_RX_PARITY_EN
  parameter int unsigned PARITY_ODD  = 0,
`endif
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RTS_MARGIN  = 2
) (
  input  logic                          io_clock,
  input  logic                          io_reset,
  input  logic                          io_rxd,
  output logic                          io_rts,
  output logic                          io_data_valid,
  input  logic                          io_data_ready,
  output logic [7:0]                    io_data_payload,
  output logic [$clog2(FIFO_DEPTH):0]   io_level,
  output logic                          io_frameError,
`ifdef UART_RX_PARITY_EN
  output logic                          io_parityError,
`endif
  output logic                          io_overflow
);

  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StWaitIdle
  } state_e;

  // Synchronizer, edge detect and arming
  logic       rx_meta_q, rxs_q, rxs_prev_q, armed_q, fall;
  logic [1:0] sync_fill_q;

  // A line held low across reset release must go high once before a start edge counts.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      sync_fill_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      rx_meta_q   <= io_rxd;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      if (sync_fill_q[1] && rxs_q) armed_q <= 1'b1;
    end
  end

  assign fall = armed_q & rxs_prev_q & ~rxs_q;

  // Tick generator
  state_e        state_q;
  logic [DW-1:0] div_cnt_q;
  logic          tick, start_det;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign start_det = (state_q == StIdle) && fall;

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      div_cnt_q <= '0;
    end else if (start_det || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  // Receive FSM
  logic [OW-1:0] os_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          push_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic parity_bad_q, parity_err_q;
`endif

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      state_q      <= StIdle;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (fall) begin
            state_q  <= StStart;
            os_cnt_q <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (os_cnt_q == OS_HALF) begin
              os_cnt_q  <= '0;
              bit_idx_q <= '0;
              state_q   <= rxs_q ? StIdle : StData;
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
        StData: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              shift_q   <= {rxs_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_idx_q == 3'd7) state_q <= StParity;
`else
              if (bit_idx_q == 3'd7) state_q <= StStop;
`endif
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q     <= '0;
              parity_bad_q <= ((^shift_q) ^ rxs_q) != PAR_ODD;
              state_q      <= StStop;
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q <= '0;
              // Back to idle mid-stop-bit so a back-to-back start edge is not missed.
              if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                if (parity_bad_q) parity_err_q <= 1'b1;
                else              push_q       <= 1'b1;
`else
                push_q <= 1'b1;
`endif
                state_q <= StIdle;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StWaitIdle;
              end
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
        StWaitIdle: begin
          if (rxs_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, level, free;
  logic        full, pop, wr_en, overflow_q, rts_q;

  assign level = wr_ptr_q - rd_ptr_q;
  assign free  = DEPTH_L - level;
  assign full  = (level == DEPTH_L);
  assign pop   = io_data_valid & io_data_ready;
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge io_clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rts_q      <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      overflow_q <= push_q & full & ~pop;
      rts_q      <= (32'(free) <= RTS_MARGIN);
    end
  end

  assign io_data_valid   = (level != '0);
  assign io_data_payload = mem_q[rd_ptr_q[AW-1:0]];
  assign io_level        = level;
  assign io_rts          = rts_q;
  assign io_frameError   = frame_err_q;
  assign io_overflow     = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign io_parityError  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are generated bit by bit, expected bytes are queued
// at send time and a monitor checks every FIFO handshake against that queue.
module tb_uart_rx_fifo;

  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int DIV    = 4;
  localparam int CLK_HZ = BAUD * OS * DIV;
  localparam int BIT    = OS * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS        = 11;
  localparam bit PARITY_BUILT = 1'b1;
  localparam bit PAR_ODD      = 1'b0;
`else
  localparam int NBITS        = 10;
  localparam bit PARITY_BUILT = 1'b0;
`endif
  // Clock edge, counted from the start-bit edge, on which the stop bit is sampled:
  // two synchronizer flops plus edge register, half a bit, then the remaining bit periods.
  localparam int STOP_EDGE = 3 + (OS / 2) * DIV + (NBITS - 1) * BIT;

  logic       clk, rst_n, rxd, ready;
  logic       rts, valid, frame_error, overflow, parity_error;
  logic [7:0] payload;
  logic [4:0] level;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .RTS_MARGIN (MARGIN)
  ) dut (
    .io_clock       (clk),
    .io_reset       (rst_n),
    .io_rxd         (rxd),
    .io_rts         (rts),
    .io_data_valid  (valid),
    .io_data_ready  (ready),
    .io_data_payload(payload),
    .io_level       (level),
    .io_frameError  (frame_error),
`ifdef UART_RX_PARITY_EN
    .io_parityError (parity_error),
`endif
    .io_overflow    (overflow)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
  int n_ferr = 0, n_ovf = 0, n_perr = 0, n_valid_cyc = 0, max_level = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    step(n);
  endtask

  // Monitor: error pulse counters and payload check on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error)  n_ferr++;
      if (overflow)     n_ovf++;
      if (parity_error) n_perr++;
      if (valid)        n_valid_cyc++;
      if (int'(level) > max_level) max_level = int'(level);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte", payload);
        end else begin
          check("payload", int'(payload), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // One frame; pop_at pulses ready for one cycle at that edge, reset_at aborts with reset low.
  task automatic send_byte(input logic [7:0] b, input bit stop_bit = 1'b1,
                           input bit par_flip = 1'b0, input bit rand_ready = 1'b0,
                           input int pop_at = -1, input int reset_at = -1);
    logic [NBITS-1:0] frame;
`ifdef UART_RX_PARITY_EN
    frame = {stop_bit, (^b) ^ PAR_ODD ^ par_flip, b, 1'b0};
`else
    frame = {stop_bit, b, 1'b0};
`endif
    if (reset_at < 0) begin
      if (!stop_bit)                                exp_ferr++;
      else if (par_flip && PARITY_BUILT)            exp_perr++;
      else if (exp_q.size() >= DEPTH && pop_at < 0) exp_ovf++;
      else                                          exp_q.push_back(b);
    end
    for (int c = 0; c < NBITS * BIT; c++) begin
      if (c == reset_at) begin
        rst_n = 1'b0;
        exp_q.delete();
        return;
      end
      rxd = frame[c / BIT];
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      if (c == pop_at) ready = 1'b1;
      if (pop_at >= 0 && c == pop_at + 1) ready = 1'b0;
      step(1);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && t < 8 * DEPTH) begin
      step(1);
      t++;
    end
    step(4);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    step(3);
    check("reset_valid", valid, 0);
    check("reset_level", level, 0);
    check("reset_rts", rts, 1);
    check("reset_frame_error", frame_error, 0);
    check("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    step(1);
    check("rts_after_release", rts, 0);
    step(10);

    // Single byte with the consumer always ready
    ready     = 1'b1;
    vc        = n_valid_cyc;
    max_level = 0;
    send_byte(8'hA5);
    idle(BIT);
    check("a5_valid_cycles", n_valid_cyc - vc, 1);
    check("a5_max_level", max_level, 1);
    check("a5_level_after", level, 0);
    check("a5_received", exp_q.size(), 0);

    // Start-bit glitch of three ticks, then a real byte
    vc  = n_valid_cyc;
    rxd = 1'b0;
    step(3 * DIV);
    idle(2 * BIT);
    check("glitch_no_byte", n_valid_cyc - vc, 0);
    send_byte(8'h3C);
    idle(BIT);
    check("3c_received", exp_q.size(), 0);

    // Bad stop bit, then a long break, then a good byte
    send_byte(8'h55, 1'b0);
    rxd = 1'b0;
    step(20 * BIT);
    idle(BIT);
    check("frame_error_count", n_ferr, exp_ferr);
    send_byte(8'h0F);
    idle(BIT);
    check("0f_received", exp_q.size(), 0);

    // Random bytes with a randomly stalling consumer
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom), 1'b1, 1'b0, 1'b1);
      idle($urandom_range(1, BIT));
    end
    drain("random_drain");

    // Fill to overflow with the consumer stalled
    ready     = 1'b0;
    max_level = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(8'(i));
      idle(BIT / 2);
      if (i == DEPTH - MARGIN - 2) check("rts_at_13", rts, 0);
      if (i == DEPTH - MARGIN - 1) check("rts_at_14", rts, 1);
      if (i == DEPTH - 1)          check("level_full", level, DEPTH);
    end
    check("level_saturated", level, DEPTH);
    check("max_level", max_level, DEPTH);
    check("overflow_count", n_ovf, exp_ovf);
    drain("overflow_drain");

    // Full FIFO with a pop on the very cycle the next byte is pushed
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(8'h20 + i));
      idle(BIT / 2);
    end
    check("level_full2", level, DEPTH);
    send_byte(8'h30, 1'b1, 1'b0, 1'b0, STOP_EDGE);
    idle(BIT / 2);
    check("level_push_pop", level, DEPTH);
    check("overflow_push_pop", n_ovf, exp_ovf);
    drain("push_pop_drain");

    // Reset in the middle of a frame with three bytes held
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom));
      idle(BIT / 2);
    end
    check("level_three", level, 3);
    send_byte(8'h81, 1'b1, 1'b0, 1'b0, -1, 2 * BIT + BIT / 2);
    step(3);
    rst_n = 1'b1;
    step(2);
    check("post_reset_valid", valid, 0);
    check("post_reset_level", level, 0);
    step(2 * BIT);
    check("low_line_no_frame", level, 0);
    check("low_line_no_error", n_ferr, exp_ferr);
    idle(BIT);
    ready = 1'b1;
    send_byte(8'h7E);
    idle(BIT);
    check("7e_received", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h03);
    idle(BIT);
    send_byte(8'h03, 1'b1, 1'b1);
    idle(BIT);
    check("parity_good_received", exp_q.size(), 0);
    check("parity_error_count", n_perr, exp_perr);
`endif

    drain("final_drain");
    check("final_frame_errors", n_ferr, exp_ferr);
    check("final_overflows", n_ovf, exp_ovf);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
